// File: rtl/reg_file_pkg.sv
// ============================================================================
// reg_file_pkg : constants shared by the register file, RoB, dispatcher and RS
// Revision     : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;
  localparam int RF_REG_NUM = 32;
  localparam int RF_TAG_W   = 5;
  localparam int REG_IDX_W  = 5;
  localparam int DATA_W     = 32;
  localparam int ROB_SIZE   = 16;
  // Tag 0 marks "no pending producer"; RoB slots map to tags 1..ROB_SIZE.
  localparam logic [RF_TAG_W-1:0] TAG_READY = '0;
endpackage

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================================
// reg_read_port : one dispatcher source lookup with same-cycle commit bypass
// Revision      : 1.0
// ============================================================================
`default_nettype none

module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int TAG_W = RF_TAG_W
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 commit_flag,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [TAG_W-1:0]     commit_q,
  input  logic [DATA_W-1:0]    commit_v,
  input  logic [TAG_W-1:0]     stored_q,
  input  logic [DATA_W-1:0]    stored_v,
  output logic [TAG_W-1:0]     q,
  output logic [DATA_W-1:0]    v
);

  always_comb begin
    q = TAG_W'(TAG_READY);
    v = '0;
    if (rs != '0) begin
      // Forward only when the committing instruction is still the newest producer.
      if (commit_flag && (commit_rd == rs) && (stored_q == commit_q)) begin
        v = commit_v;
      end else begin
        q = stored_q;
        v = stored_v;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// reg_file : architectural register file holding values and rename tags
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM = RF_REG_NUM,
  parameter int TAG_W   = RF_TAG_W
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 rollback_flag_from_rob,
  input  logic                 commit_flag_from_rob,
  input  logic [REG_IDX_W-1:0] rd_from_rob,
  input  logic [TAG_W-1:0]     Q_from_rob,
  input  logic [DATA_W-1:0]    V_from_rob,
  input  logic [REG_IDX_W-1:0] rs1_from_dispatcher,
  input  logic [REG_IDX_W-1:0] rs2_from_dispatcher,
  output logic [TAG_W-1:0]     Q1_to_dispatcher,
  output logic [TAG_W-1:0]     Q2_to_dispatcher,
  output logic [DATA_W-1:0]    V1_to_dispatcher,
  output logic [DATA_W-1:0]    V2_to_dispatcher,
  input  logic                 en_signal_from_dispatcher,
  input  logic [REG_IDX_W-1:0] rd_from_dispatcher,
  input  logic [TAG_W-1:0]     rob_id_from_dispatcher
);

  logic [DATA_W-1:0] v_mem [REG_NUM];
  logic [TAG_W-1:0]  q_mem [REG_NUM];

  reg_read_port #(.TAG_W(TAG_W)) u_read_rs1 (
    .rs          (rs1_from_dispatcher),
    .commit_flag (commit_flag_from_rob),
    .commit_rd   (rd_from_rob),
    .commit_q    (Q_from_rob),
    .commit_v    (V_from_rob),
    .stored_q    (q_mem[rs1_from_dispatcher]),
    .stored_v    (v_mem[rs1_from_dispatcher]),
    .q           (Q1_to_dispatcher),
    .v           (V1_to_dispatcher)
  );

  reg_read_port #(.TAG_W(TAG_W)) u_read_rs2 (
    .rs          (rs2_from_dispatcher),
    .commit_flag (commit_flag_from_rob),
    .commit_rd   (rd_from_rob),
    .commit_q    (Q_from_rob),
    .commit_v    (V_from_rob),
    .stored_q    (q_mem[rs2_from_dispatcher]),
    .stored_v    (v_mem[rs2_from_dispatcher]),
    .q           (Q2_to_dispatcher),
    .v           (V2_to_dispatcher)
  );

  // Later assignments override earlier ones: rename beats the commit tag clear,
  // and rollback beats both.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_mem[i] <= '0;
        q_mem[i] <= TAG_W'(TAG_READY);
      end
    end else if (rdy_in) begin
      if (commit_flag_from_rob && (rd_from_rob != '0)) begin
        v_mem[rd_from_rob] <= V_from_rob;
        if (q_mem[rd_from_rob] == Q_from_rob) begin
          q_mem[rd_from_rob] <= TAG_W'(TAG_READY);
        end
      end
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < REG_NUM; i++) begin
          q_mem[i] <= TAG_W'(TAG_READY);
        end
      end else if (en_signal_from_dispatcher && (rd_from_dispatcher != '0)) begin
        q_mem[rd_from_dispatcher] <= rob_id_from_dispatcher;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : scoreboard bench for reg_file, directed cases plus random traffic
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rollback_flag_from_rob = 1'b0;
  logic        commit_flag_from_rob = 1'b0;
  logic [4:0]  rd_from_rob = '0;
  logic [4:0]  Q_from_rob = '0;
  logic [31:0] V_from_rob = '0;
  logic [4:0]  rs1_from_dispatcher = '0;
  logic [4:0]  rs2_from_dispatcher = '0;
  logic [4:0]  Q1_to_dispatcher, Q2_to_dispatcher;
  logic [31:0] V1_to_dispatcher, V2_to_dispatcher;
  logic        en_signal_from_dispatcher = 1'b0;
  logic [4:0]  rd_from_dispatcher = '0;
  logic [4:0]  rob_id_from_dispatcher = '0;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [4:0]  q1;
    logic [31:0] v1;
    logic [4:0]  q2;
    logic [31:0] v2;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain arrays holding the architectural state.
  logic [31:0] mv [32];
  logic [4:0]  mq [32];

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .rollback_flag_from_rob    (rollback_flag_from_rob),
    .commit_flag_from_rob      (commit_flag_from_rob),
    .rd_from_rob               (rd_from_rob),
    .Q_from_rob                (Q_from_rob),
    .V_from_rob                (V_from_rob),
    .rs1_from_dispatcher       (rs1_from_dispatcher),
    .rs2_from_dispatcher       (rs2_from_dispatcher),
    .Q1_to_dispatcher          (Q1_to_dispatcher),
    .Q2_to_dispatcher          (Q2_to_dispatcher),
    .V1_to_dispatcher          (V1_to_dispatcher),
    .V2_to_dispatcher          (V2_to_dispatcher),
    .en_signal_from_dispatcher (en_signal_from_dispatcher),
    .rd_from_dispatcher        (rd_from_dispatcher),
    .rob_id_from_dispatcher    (rob_id_from_dispatcher)
  );

  // Apply the effect of the inputs the DUT just sampled at the clock edge.
  task automatic model_update();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        mv[i] = '0;
        mq[i] = '0;
      end
    end else if (rdy_in) begin
      if (commit_flag_from_rob && rd_from_rob != 0) begin
        mv[rd_from_rob] = V_from_rob;
        if (mq[rd_from_rob] == Q_from_rob) mq[rd_from_rob] = '0;
      end
      if (rollback_flag_from_rob) begin
        for (int i = 0; i < 32; i++) mq[i] = '0;
      end else if (en_signal_from_dispatcher && rd_from_dispatcher != 0) begin
        mq[rd_from_dispatcher] = rob_id_from_dispatcher;
      end
    end
  endtask

  task automatic model_read(input logic [4:0] rs, output logic [4:0] q, output logic [31:0] v);
    if (rs == 0) begin
      q = '0;
      v = '0;
    end else if (commit_flag_from_rob && rd_from_rob == rs && mq[rs] == Q_from_rob) begin
      q = '0;
      v = V_from_rob;
    end else begin
      q = mq[rs];
      v = mv[rs];
    end
  endtask

  // Wait for the edge, fold the sampled inputs into the model, then go idle.
  task automatic tick();
    @(posedge clk_in);
    #1;
    model_update();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rollback_flag_from_rob = 1'b0;
    commit_flag_from_rob = 1'b0;
    rd_from_rob = '0;
    Q_from_rob = '0;
    V_from_rob = '0;
    rs1_from_dispatcher = '0;
    rs2_from_dispatcher = '0;
    en_signal_from_dispatcher = 1'b0;
    rd_from_dispatcher = '0;
    rob_id_from_dispatcher = '0;
  endtask

  task automatic push(input string tag);
    exp_t e;
    model_read(rs1_from_dispatcher, e.q1, e.v1);
    model_read(rs2_from_dispatcher, e.q2, e.v2);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic commit(input logic [4:0] rd, input logic [4:0] q, input logic [31:0] v);
    commit_flag_from_rob = 1'b1;
    rd_from_rob = rd;
    Q_from_rob = q;
    V_from_rob = v;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [4:0] id);
    en_signal_from_dispatcher = 1'b1;
    rd_from_dispatcher = rd;
    rob_id_from_dispatcher = id;
  endtask

  // Monitor: the outputs are combinational, so each cycle's read is checked mid-cycle.
  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (Q1_to_dispatcher !== e.q1 || V1_to_dispatcher !== e.v1 ||
          Q2_to_dispatcher !== e.q2 || V2_to_dispatcher !== e.v2) begin
        fails++;
        $display("FAIL %s: got Q1=%0d V1=%h Q2=%0d V2=%h, expected Q1=%0d V1=%h Q2=%0d V2=%h",
                 e.tag, Q1_to_dispatcher, V1_to_dispatcher, Q2_to_dispatcher, V2_to_dispatcher,
                 e.q1, e.v1, e.q2, e.v2);
      end
    end
  end

  initial begin
    logic [4:0] r;
    for (int i = 0; i < 32; i++) begin
      mv[i] = '0;
      mq[i] = '0;
    end

    tick(); rs1_from_dispatcher = 5; rs2_from_dispatcher = 0; push("reset_read");

    tick(); rename(5, 3); rs1_from_dispatcher = 5; push("rename_old_view");
    tick(); rs1_from_dispatcher = 5; push("rename_tag_visible");
    tick(); commit(5, 3, 32'h1234); rs1_from_dispatcher = 5; push("commit_bypass");
    tick(); rs1_from_dispatcher = 5; push("commit_stored");

    tick(); rename(7, 2); push("stale_rename_a");
    tick(); rename(7, 4); push("stale_rename_b");
    tick(); commit(7, 2, 32'hAA); rs1_from_dispatcher = 7; push("stale_no_bypass");
    tick(); rs1_from_dispatcher = 7; rs2_from_dispatcher = 5; push("stale_stored");

    tick(); rename(9, 6); push("same_cycle_prep");
    tick(); commit(9, 6, 32'h55); rename(9, 8); rs1_from_dispatcher = 9; push("same_cycle_bypass");
    tick(); rs1_from_dispatcher = 9; push("same_cycle_result");

    tick(); commit(4, 0, 32'h44); push("rb_prep_v4");
    tick(); rename(1, 2); push("rb_prep_x1");
    tick(); rename(3, 5); rs1_from_dispatcher = 1; rs2_from_dispatcher = 3; push("rb_prep_x3");
    tick(); commit(1, 2, 32'h80); rollback_flag_from_rob = 1'b1; rename(4, 7);
    rs1_from_dispatcher = 1; rs2_from_dispatcher = 3; push("rb_same_cycle");
    tick(); rs1_from_dispatcher = 1; rs2_from_dispatcher = 3; push("rb_x1_x3");
    tick(); rs1_from_dispatcher = 4; rs2_from_dispatcher = 9; push("rb_x4_x9");

    tick(); commit(0, 0, 32'hFF); rename(0, 9); push("x0_write");
    tick(); rs1_from_dispatcher = 0; rs2_from_dispatcher = 0; push("x0_read");
    tick(); rdy_in = 1'b0; commit(2, 0, 32'h22); rename(2, 11); rs1_from_dispatcher = 2; push("rdy_low");
    tick(); rs1_from_dispatcher = 2; push("rdy_hold");

    for (int n = 0; n < 600; n++) begin
      tick();
      rdy_in = ($urandom_range(0, 9) != 0);
      rst_in = ($urandom_range(0, 199) == 0);
      rollback_flag_from_rob = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) begin
        r = 5'($urandom_range(0, 31));
        commit(r, ($urandom_range(0, 2) != 0) ? mq[r] : 5'($urandom_range(0, 16)), $urandom);
      end
      if ($urandom_range(0, 2) != 0) rename(5'($urandom_range(0, 31)), 5'($urandom_range(1, 16)));
      // Bias reads toward the committing register so the bypass path is exercised.
      rs1_from_dispatcher = ($urandom_range(0, 2) == 0) ? rd_from_rob : 5'($urandom_range(0, 31));
      rs2_from_dispatcher = ($urandom_range(0, 3) == 0) ? rd_from_dispatcher : 5'($urandom_range(0, 31));
      push("random");
    end

    tick();
    @(posedge clk_in);
    @(posedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags.
- Sits at the far end of the RoB commit interface: consumes the RoB's commit value, rd and tag (rd/Q/V) and its rollback pulse.
- Serves the dispatcher: per source register, returns either a value or the RoB tag that will produce it.
- Records the tag of each newly dispatched destination register.

Parameters:
REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
TAG_W, 5, RoB tag width; tag 0 = "no pending producer", tags 1..16 = RoB slot+1

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; low = hold all state
rollback_flag_from_rob  input  1  flush all rename tags
commit_flag_from_rob  input  1  commit valid this cycle
rd_from_rob  input  5  committing destination register
Q_from_rob  input  TAG_W  tag of committing instruction
V_from_rob  input  32  committed value
rs1_from_dispatcher  input  5  source 1 index
rs2_from_dispatcher  input  5  source 2 index
Q1_to_dispatcher  output  TAG_W  pending tag for rs1 (0 = value valid)
Q2_to_dispatcher  output  TAG_W  pending tag for rs2
V1_to_dispatcher  output  32  value for rs1 (meaningful when Q1=0)
V2_to_dispatcher  output  32  value for rs2
en_signal_from_dispatcher  input  1  rename request this cycle
rd_from_dispatcher  input  5  destination being renamed
rob_id_from_dispatcher  input  TAG_W  RoB tag allocated to it

Behaviour:
Reset and hold:
- Reset is synchronous and active-high: one clock, clk_in; rst_in synchronous active-high.
- On rst_in: all V[i]=0, all Q[i]=0. Outputs are combinational, so they read Q=0, V=0 for every index the cycle after reset.
- rdy_in=0 (and not rst_in): no state change.

State: V[0..31] (32b) and Q[0..31] (TAG_W). Index 0 never written; always reads V=0, Q=0.

Read (combinational, zero latency), per port, rsN:
- rsN==0 -> Q=0, V=0.
- Else, if commit_flag_from_rob && rd_from_rob==rsN && Q[rsN]==Q_from_rob -> bypass: Q=0, V=V_from_rob.
- Else -> Q=Q[rsN], V=V[rsN].
- The read reflects state before this cycle's rename. An instruction reading its own rd sees the old producer.
- Rollback does not alter same-cycle reads.

Commit (posedge), when commit_flag_from_rob && rd_from_rob!=0:
- V[rd] <= V_from_rob.
- If Q[rd]==Q_from_rob, Q[rd] <= 0. Otherwise the tag is left unchanged, because a younger producer is pending.
- Commit with rd=0 (stores, branches) changes nothing.

Rename (posedge), when en_signal_from_dispatcher && rd_from_dispatcher!=0 && !rollback_flag_from_rob:
- Q[rd] <= rob_id_from_dispatcher.

Simultaneous events:
- Commit and rename to the same rd in the same cycle: the value write still happens; the rename tag wins over the tag clear.
- Rollback (commit_flag and rollback_flag arrive together from the RoB for a mispredicted jump):
  - The commit value write is performed first (jal/jalr link value must land).
  - All Q[i] <= 0; any same-cycle rename is dropped.
  - V of other registers is unchanged.
- rst_in has priority over everything, including mid-rollback.

Invariants:
- Tag values are never interpreted arithmetically; they are compared for equality only.
- TAG_W truncation is not permitted.
- Q[i] is never nonzero for i=0.

Decomposition:
- Shared defines header gets: TAG_W, REG_NUM, the "tag 0 = ready" constant, and RoB size (16). These are shared with the RoB, dispatcher and reservation stations.
- One natural sub-module: reg_read_port, the combinational bypass/lookup for one source. It is instantiated twice (rs1, rs2).
- Sequential state stays in reg_file.

Test Plan:
1. Reset, then read rs1=5, rs2=0 -> Q1=0, V1=0, Q2=0, V2=0.
2. Rename x5 with tag 3; next cycle read x5 -> Q1=3. Then commit rd=5, Q=3, V=0x1234. In the same cycle as that commit, read x5 -> Q1=0, V1=0x1234 (bypass). Next cycle read x5 -> Q1=0, V1=0x1234 (stored).
3. Stale commit: rename x7 with tag 2, then rename x7 with tag 4, then commit rd=7, Q=2, V=0xAA -> V[7]=0xAA, Q[7]=4. The same-cycle read of x7 returns Q=4, no bypass.
4. Same-cycle commit and rename: x9 has Q=6; commit rd=9, Q=6, V=0x55 while renaming x9 to tag 8 -> next cycle Q[9]=8, V[9]=0x55.
5. Rollback: x1 has Q=2, x3 has Q=5. Commit rd=1, Q=2, V=0x80 with rollback_flag=1 and a rename x4->tag 7 -> V[1]=0x80, Q[1]=Q[3]=Q[4]=0, and x4 keeps its old V.
6. x0 and rdy: commit rd=0, V=0xFF and rename rd=0 -> x0 reads Q=0, V=0. With rdy_in=0, a commit to x2 -> V[2] unchanged.
